// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: STUMPS-style logic-BIST controller (PRPG + phase shifter -> 7 chains -> MISR).
// Optional run abort input is compiled in when SCAN_BIST_ABORT_EN is defined.
module scan_bist_ctrl #(
  parameter int          CHAIN_LEN = 40,
  parameter int          NUM_PAT_W = 16,
  parameter logic [15:0] PRPG_SEED = 16'hACE1,
  parameter logic [15:0] MISR_POLY = 16'h1021
) (
  input  logic                 CK,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_PAT_W-1:0] num_pat,
  input  logic [15:0]          expected_sig,
`ifdef SCAN_BIST_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [6:0]           SO_chain,
  output logic [6:0]           SI_chain,
  output logic                 scan_en,
  output logic                 test_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          signature
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     shift_cnt_r;
  logic [NUM_PAT_W-1:0] pat_left_r;
  logic                 first_load_r;
  logic [15:0]          prpg_r;
  logic [15:0]          misr_r;
  logic [15:0]          misr_nxt_s;
  logic                 done_r;
  logic                 pass_r;
  logic                 busy_s;
  logic                 start_ok_s;
  logic                 last_shift_s;
  logic                 abort_s;

  function automatic logic [15:0] prpg_step(input logic [15:0] p);
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [6:0] so);
    return {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000) ^ {9'b0_0000_0000, so};
  endfunction

  function automatic logic [6:0] phase_shift(input logic [15:0] p);
    return p[6:0] ^ p[13:7];
  endfunction

`ifdef SCAN_BIST_ABORT_EN
  assign abort_s = abort & busy_s;
`else
  assign abort_s = 1'b0;
`endif

  assign busy_s       = (state_r == ST_SHIFT) || (state_r == ST_CAPTURE);
  assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_shift_s = (state_r == ST_SHIFT) && (shift_cnt_r == LAST_CNT);
  assign misr_nxt_s   = misr_step(misr_r, SO_chain);

  // FSM state register
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = (num_pat == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SHIFT: begin
        if (abort_s) begin
          state_nxt_s = ST_DONE;
        end else if (last_shift_s) begin
          state_nxt_s = (pat_left_r == '0) ? ST_DONE : ST_CAPTURE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_CAPTURE: begin
        if (abort_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pattern generator, compactor, counters and result flags
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt_r  <= '0;
      pat_left_r   <= '0;
      first_load_r <= 1'b1;
      prpg_r       <= PRPG_SEED;
      misr_r       <= 16'h0000;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else if (start_ok_s) begin
      shift_cnt_r  <= '0;
      pat_left_r   <= num_pat;
      first_load_r <= 1'b1;
      prpg_r       <= PRPG_SEED;
      misr_r       <= 16'h0000;
      done_r       <= (num_pat == '0);
      pass_r       <= (num_pat == '0) && (expected_sig == 16'h0000);
    end else if (abort_s) begin
      // MISR and PRPG freeze so the partial signature stays observable
      done_r <= 1'b1;
      pass_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_SHIFT: begin
          prpg_r <= prpg_step(prpg_r);
          if (!first_load_r) begin
            misr_r <= misr_nxt_s;
          end
          if (last_shift_s) begin
            shift_cnt_r <= '0;
            if (pat_left_r == '0) begin
              done_r <= 1'b1;
              pass_r <= (misr_nxt_s == expected_sig);
            end else begin
              pat_left_r   <= pat_left_r - NUM_PAT_W'(1);
              first_load_r <= 1'b0;
            end
          end else begin
            shift_cnt_r <= shift_cnt_r + CNT_W'(1);
          end
        end
        ST_CAPTURE: shift_cnt_r <= '0;
        default:    shift_cnt_r <= shift_cnt_r;
      endcase
    end
  end

  assign SI_chain  = (state_r == ST_SHIFT) ? phase_shift(prpg_r) : 7'h00;
  assign scan_en   = (state_r == ST_SHIFT);
  assign test_en   = busy_s;
  assign busy      = busy_s;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = misr_r;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Self-checking bench for scan_bist_ctrl: vector table, randomized runs against a
// schedule-level reference model, loopback, mid-run reset and (if enabled) abort.
module tb_scan_bist_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] POLY = 16'h1021;

  logic        CK = 1'b0;
  logic        rst_n;
  logic        start4, start40;
  logic [15:0] num_pat, expected_sig;
  logic [6:0]  so_chain;
`ifdef SCAN_BIST_ABORT_EN
  logic        abort;
`endif

  logic [6:0]  si4, si40;
  logic        se4, se40, te4, te40, busy4, busy40, done4, done40, pass4, pass40;
  logic [15:0] sig4, sig40;

  bit          sel;
  logic [6:0]  si_s;
  logic        se_s, te_s, busy_s, done_s, pass_s;
  logic [15:0] sig_s;

  assign si_s   = sel ? si40   : si4;
  assign se_s   = sel ? se40   : se4;
  assign te_s   = sel ? te40   : te4;
  assign busy_s = sel ? busy40 : busy4;
  assign done_s = sel ? done40 : done4;
  assign pass_s = sel ? pass40 : pass4;
  assign sig_s  = sel ? sig40  : sig4;

  always #5 CK = ~CK;

  scan_bist_ctrl #(.CHAIN_LEN(4)) u_dut4 (
    .CK(CK), .rst_n(rst_n), .start(start4), .num_pat(num_pat), .expected_sig(expected_sig),
`ifdef SCAN_BIST_ABORT_EN
    .abort(abort),
`endif
    .SO_chain(so_chain), .SI_chain(si4), .scan_en(se4), .test_en(te4), .busy(busy4),
    .done(done4), .pass(pass4), .signature(sig4)
  );

  scan_bist_ctrl #(.CHAIN_LEN(40)) u_dut40 (
    .CK(CK), .rst_n(rst_n), .start(start40), .num_pat(num_pat), .expected_sig(expected_sig),
`ifdef SCAN_BIST_ABORT_EN
    .abort(abort),
`endif
    .SO_chain(so_chain), .SI_chain(si40), .scan_en(se40), .test_en(te40), .busy(busy40),
    .done(done40), .pass(pass40), .signature(sig40)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  m_si   [0:2047];
  logic [6:0]  m_so   [0:2047];
  logic [6:0]  rnd_so [0:2047];
  logic [6:0]  obs_si [0:2047];
  logic [15:0] m_sig;
  int          m_len;

  typedef struct {
    bit          s;
    int          n;
    logic [6:0]  so;
    logic [15:0] exp_sig;
    int          len;
    logic [15:0] sig;
    bit          pass;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] p);
    int v, fb;
    v  = int'(p);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] m, input logic [6:0] so);
    int v;
    v = (int'(m) << 1) & 32'hFFFF;
    if (((int'(m) >> 15) & 1) == 1) v = v ^ int'(POLY);
    v = v ^ int'(so);
    return 16'(v);
  endfunction

  function automatic logic [6:0] ref_phase(input logic [15:0] p);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = 1'(((int'(p) >> i) ^ (int'(p) >> (i + 7))) & 1);
    return r;
  endfunction

  // Walks the run as a list of cycles: (N+1) loads of cl shifts separated by single captures.
  task automatic build_model(input int cl, input int n, input int mode, input logic [6:0] cval);
    logic [15:0] p, m;
    bit first;
    int j;
    p = SEED; m = 16'h0000; first = 1'b1; j = 0;
    for (int pat = 0; pat <= n; pat++) begin
      for (int s = 0; s < cl; s++) begin
        m_si[j] = ref_phase(p);
        m_so[j] = (mode == 0) ? cval : (mode == 1) ? rnd_so[j] : ((j >= cl) ? m_si[j - cl] : 7'h00);
        if (!first) m = ref_misr(m, m_so[j]);
        p = ref_lfsr(p);
        j++;
      end
      if (pat < n) begin
        m_si[j] = 7'h00;
        first = 1'b0;
        j++;
      end
    end
    m_sig = m;
    m_len = j;
  endtask

  // Starts a run on the selected DUT (called #1 after an edge) and checks it to completion.
  task automatic run_check(input bit s, input int n, input int mode, input logic [6:0] cval,
                           input logic [15:0] exp_sig, input int exp_len,
                           input logic [15:0] exp_signature, input bit exp_pass, input string name);
    int cl, done_at, se_low, busy_cnt;
    cl = s ? 40 : 4;
    sel = s;
    build_model(cl, n, mode, cval);
    num_pat = 16'(n);
    expected_sig = exp_sig;
    so_chain = cval;
    if (s) start40 = 1'b1; else start4 = 1'b1;
    @(posedge CK); #1;
    start4 = 1'b0; start40 = 1'b0;
    done_at = -1; se_low = 0; busy_cnt = 0;
    for (int j = 0; j < 1500; j++) begin
      if (done_s) begin
        done_at = j;
        break;
      end
      if (j < m_len) chk({name, "_si"}, 32'(si_s), 32'(m_si[j]));
      obs_si[j] = si_s;
      if (!se_s) se_low++;
      if (busy_s) busy_cnt++;
      so_chain = (mode == 0) ? cval : (mode == 1) ? rnd_so[j] : ((j >= cl) ? obs_si[j - cl] : 7'h00);
      @(posedge CK); #1;
    end
    chk({name, "_latency"}, 32'(done_at), 32'(exp_len));
    chk({name, "_sig"}, 32'(sig_s), 32'(exp_signature));
    chk({name, "_pass"}, 32'(pass_s), 32'(exp_pass));
    chk({name, "_busy_at_done"}, 32'(busy_s), 32'd0);
    chk({name, "_test_en_at_done"}, 32'(te_s), 32'd0);
    chk({name, "_scan_en_low_cycles"}, 32'(se_low), 32'(n));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_len));
    @(posedge CK); #1;
    chk({name, "_done_width"}, 32'(done_s), 32'd0);
    chk({name, "_sig_hold"}, 32'(sig_s), 32'(exp_signature));
    chk({name, "_pass_hold"}, 32'(pass_s), 32'(exp_pass));
  endtask

  initial begin
    logic [15:0] es;
    int done_cnt, busy_cnt;
    rst_n = 1'b0; start4 = 1'b0; start40 = 1'b0; sel = 1'b0;
    num_pat = 16'h0000; expected_sig = 16'h0000; so_chain = 7'h00;
`ifdef SCAN_BIST_ABORT_EN
    abort = 1'b0;
`endif
    // latency = edges from the accepted start edge to the edge that raises done
    tbl[0] = '{s: 1'b0, n: 1, so: 7'h01, exp_sig: 16'h000F, len: 9,   sig: 16'h000F, pass: 1'b1};
    tbl[1] = '{s: 1'b0, n: 1, so: 7'h01, exp_sig: 16'h000E, len: 9,   sig: 16'h000F, pass: 1'b0};
    tbl[2] = '{s: 1'b0, n: 0, so: 7'h00, exp_sig: 16'h0000, len: 0,   sig: 16'h0000, pass: 1'b1};
    tbl[3] = '{s: 1'b1, n: 3, so: 7'h00, exp_sig: 16'h0000, len: 163, sig: 16'h0000, pass: 1'b1};
    tbl[4] = '{s: 1'b1, n: 0, so: 7'h55, exp_sig: 16'h1234, len: 0,   sig: 16'h0000, pass: 1'b0};

    repeat (2) @(posedge CK);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #0;
      chk("reset_si", 32'(si_s), 32'd0);
      chk("reset_scan_en", 32'(se_s), 32'd0);
      chk("reset_test_en", 32'(te_s), 32'd0);
      chk("reset_busy", 32'(busy_s), 32'd0);
      chk("reset_done", 32'(done_s), 32'd0);
      chk("reset_pass", 32'(pass_s), 32'd0);
      chk("reset_sig", 32'(sig_s), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge CK); #1;

    for (int t = 0; t < 5; t++) begin
      run_check(tbl[t].s, tbl[t].n, 0, tbl[t].so, tbl[t].exp_sig, tbl[t].len,
                tbl[t].sig, tbl[t].pass, $sformatf("vec%0d", t));
    end

    for (int r = 0; r < 6; r++) begin
      bit s;
      int n, cl;
      s  = (r % 2 == 1);
      n  = s ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 4));
      cl = s ? 40 : 4;
      for (int j = 0; j < 2048; j++) rnd_so[j] = 7'($urandom);
      build_model(cl, n, 1, 7'h00);
      es = ($urandom_range(0, 1) == 1) ? m_sig : (m_sig ^ 16'($urandom_range(1, 65535)));
      run_check(s, n, 1, 7'h00, es, (n + 1) * cl + n, m_sig, (es == m_sig), $sformatf("rand%0d", r));
    end

    for (int k = 0; k < 2; k++) begin
      build_model(40, 2, 2, 7'h00);
      es = m_sig;
      run_check(1'b1, 2, 2, 7'h00, es, 122, es, 1'b1, $sformatf("loop%0d", k));
    end

    // Reset during the 5th shift cycle of a 40-cell run
    sel = 1'b1; num_pat = 16'd3; expected_sig = 16'h0000; so_chain = 7'h00;
    start40 = 1'b1;
    @(posedge CK); #1;
    start40 = 1'b0;
    repeat (4) @(posedge CK);
    #1;
    chk("rst_mid_live_scan_en", 32'(se_s), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_si", 32'(si_s), 32'd0);
    chk("rst_mid_scan_en", 32'(se_s), 32'd0);
    chk("rst_mid_test_en", 32'(te_s), 32'd0);
    chk("rst_mid_busy", 32'(busy_s), 32'd0);
    chk("rst_mid_done", 32'(done_s), 32'd0);
    chk("rst_mid_sig", 32'(sig_s), 32'd0);
    @(posedge CK); #1;
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int j = 0; j < 200; j++) begin
      @(posedge CK); #1;
      if (done_s) done_cnt++;
      if (busy_s) busy_cnt++;
    end
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_idle", 32'(busy_cnt), 32'd0);

`ifdef SCAN_BIST_ABORT_EN
    // Abort during the 2nd capture of a 5-pattern run on the 4-cell DUT
    sel = 1'b0; num_pat = 16'd5; expected_sig = 16'h000F; so_chain = 7'h01;
    start4 = 1'b1;
    @(posedge CK); #1;
    start4 = 1'b0;
    repeat (9) @(posedge CK);
    #1;
    chk("abort_in_capture", 32'({busy_s, se_s}), 32'h2);
    abort = 1'b1;
    @(posedge CK); #1;
    abort = 1'b0;
    chk("abort_done", 32'(done_s), 32'd1);
    chk("abort_pass", 32'(pass_s), 32'd0);
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_sig_frozen", 32'(sig_s), 32'h000F);
    run_check(tbl[0].s, tbl[0].n, 0, tbl[0].so, tbl[0].exp_sig, tbl[0].len,
              tbl[0].sig, tbl[0].pass, "after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
